// File: rtl/serial_parity_checker.sv
// serial_parity_checker: LSB-first serial-to-parallel deserialiser with even-parity check.
// Optional saturating bad-parity counter is built when ERR_CNT_EN is defined.
module serial_parity_checker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_abort,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        err_count
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_PAR  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              run_par, run_par_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              load_out;
    logic              hs_out;

    // Moore handshake outputs: decoded from state only.
    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign hs_out    = out_valid && out_ready;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        run_par_nxt = run_par;
        shreg_nxt   = shreg;
        load_out    = 1'b0;
        case (state)
            S_DATA: begin
                if (frame_abort) begin
                    bit_cnt_nxt = '0;
                    run_par_nxt = 1'b0;
                end else if (in_valid) begin
                    shreg_nxt[bit_cnt] = in_bit;
                    run_par_nxt        = run_par ^ in_bit;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt   = S_PAR;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (frame_abort) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                    run_par_nxt = 1'b0;
                end else if (in_valid) begin
                    load_out  = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Abort is ignored here: a completed word is always delivered.
                if (out_ready) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                    run_par_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = S_DATA;
                bit_cnt_nxt = '0;
                run_par_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            run_par <= 1'b0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            run_par <= run_par_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            parity_err <= 1'b0;
        end else if (load_out) begin
            data_out   <= shreg;
            parity_err <= run_par ^ in_bit;
        end
    end

`ifdef ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= 8'h00;
        else if (hs_out && parity_err && (err_count != 8'hFF))
            err_count <= err_count + 8'h01;
    end
`else
    assign err_count = 8'h00;
    logic unused_hs;
    assign unused_hs = hs_out;
`endif

endmodule
